// File: rtl/jpeg_pixel_sink.sv
// jpeg_pixel_sink: buffers the JPEG decoder's unstallable pixel stream in a
// first-word-fall-through FIFO, tags each pixel with sof/eol/eof from the image
// size latched at frame start, and offers a valid/ready stream to the frame writer.
// Optional feature: define JPEG_SINK_RGB565_EN to pack pixels as 16-bit RGB565
// instead of 24-bit {r,g,b}.

module jpeg_pixel_sink #(
    parameter int FIFO_AW = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         r_in,
    input  logic [7:0]         g_in,
    input  logic [7:0]         b_in,
    input  logic               pixel_valid,
    input  logic               dec_idle,
    input  logic [15:0]        img_width,
    input  logic [15:0]        img_height,
`ifdef JPEG_SINK_RGB565_EN
    output logic [15:0]        m_data,
`else
    output logic [23:0]        m_data,
`endif
    output logic               m_valid,
    input  logic               m_ready,
    output logic               m_sof,
    output logic               m_eol,
    output logic               m_eof,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               overflow,
    output logic               stray,
    output logic               frame_done
);

`ifdef JPEG_SINK_RGB565_EN
    localparam int DW = 16;
`else
    localparam int DW = 24;
`endif
    localparam int                 DEPTH   = 2 ** FIFO_AW;
    localparam int                 EW      = DW + 3;
    localparam logic [FIFO_AW:0]   DEPTH_L = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DRAIN
    } state_t;

    state_t               state;
    logic                 idle_q;
    logic [15:0]          width_q;
    logic [15:0]          height_q;
    logic [15:0]          x;
    logic [15:0]          y;

    logic [EW-1:0]        mem [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr;
    logic [FIFO_AW-1:0]   rd_ptr;
    logic [FIFO_AW:0]     count;

    logic [DW-1:0]        pix_data;
    logic [EW-1:0]        wr_entry;
    logic                 frame_start;
    logic                 full;
    logic                 rd_en;
    logic                 wr_en;
    logic                 cur_sof;
    logic                 cur_eol;
    logic                 cur_eof;

    // Pixel packing, tag generation and FIFO handshake decode.
    always_comb begin
`ifdef JPEG_SINK_RGB565_EN
        pix_data = {r_in[7:3], g_in[7:2], b_in[7:3]};
`else
        pix_data = {r_in, g_in, b_in};
`endif
        cur_sof     = (x == 16'd0) && (y == 16'd0);
        cur_eol     = (x == width_q - 16'd1);
        cur_eof     = cur_eol && (y == height_q - 16'd1);
        wr_entry    = {pix_data, cur_sof, cur_eol, cur_eof};
        frame_start = idle_q && !dec_idle;
        full        = (count == DEPTH_L);
        m_valid     = (count != '0);
        rd_en       = m_valid && m_ready;
        wr_en       = pixel_valid && (state == ACTIVE) && (!full || rd_en);
        fifo_level  = count;
    end

    // Head entry is gated so the outputs read zero while the FIFO is empty.
    always_comb begin
        m_data = '0;
        m_sof  = 1'b0;
        m_eol  = 1'b0;
        m_eof  = 1'b0;
        if (m_valid) begin
            {m_data, m_sof, m_eol, m_eof} = mem[rd_ptr];
        end
    end

    // FIFO storage; contents are don't-care until the pointers say otherwise.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    // FIFO pointers and occupancy; reset flushes any buffered pixels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Frame FSM: latches geometry, walks x/y, and raises the sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idle_q     <= 1'b1;
            width_q    <= '0;
            height_q   <= '0;
            x          <= '0;
            y          <= '0;
            overflow   <= 1'b0;
            stray      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            idle_q     <= dec_idle;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        width_q  <= img_width;
                        height_q <= img_height;
                        x        <= '0;
                        y        <= '0;
                        overflow <= 1'b0;
                        stray    <= 1'b0;
                        if (img_width != 16'd0 && img_height != 16'd0) begin
                            state <= ACTIVE;
                        end
                    end else if (pixel_valid) begin
                        stray <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (pixel_valid) begin
                        if (!wr_en) begin
                            overflow <= 1'b1;
                        end
                        if (cur_eof) begin
                            x     <= '0;
                            y     <= '0;
                            state <= DRAIN;
                        end else if (cur_eol) begin
                            x <= '0;
                            y <= y + 16'd1;
                        end else begin
                            x <= x + 16'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (pixel_valid) begin
                        stray <= 1'b1;
                    end
                    // Nothing is written in DRAIN, so an empty FIFO here means the
                    // eof pixel was either accepted already or lost to overflow.
                    if ((rd_en && m_eof) || !m_valid) begin
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jpeg_pixel_sink.sv
// tb_jpeg_pixel_sink: directed checks of jpeg_pixel_sink framing, overflow,
// stray detection, mid-frame reset and pixel packing.

module tb_jpeg_pixel_sink;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  r_in;
    logic [7:0]  g_in;
    logic [7:0]  b_in;
    logic        pixel_valid;
    logic        dec_idle;
    logic [15:0] img_width;
    logic [15:0] img_height;
`ifdef JPEG_SINK_RGB565_EN
    logic [15:0] m_data;
`else
    logic [23:0] m_data;
`endif
    logic        m_valid;
    logic        m_ready;
    logic        m_sof;
    logic        m_eol;
    logic        m_eof;
    logic [4:0]  fifo_level;
    logic        overflow;
    logic        stray;
    logic        frame_done;

    int vectors     = 0;
    int miscompares = 0;

    jpeg_pixel_sink #(.FIFO_AW(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .r_in        (r_in),
        .g_in        (g_in),
        .b_in        (b_in),
        .pixel_valid (pixel_valid),
        .dec_idle    (dec_idle),
        .img_width   (img_width),
        .img_height  (img_height),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_sof       (m_sof),
        .m_eol       (m_eol),
        .m_eof       (m_eof),
        .fifo_level  (fifo_level),
        .overflow    (overflow),
        .stray       (stray),
        .frame_done  (frame_done)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; outputs are sampled and
    // inputs are driven at this point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic pv, input logic [7:0] r,
                                 input logic [7:0] g, input logic [7:0] b);
        pixel_valid = pv;
        r_in        = r;
        g_in        = g;
        b_in        = b;
    endtask

    // Present a dec_idle 1->0 transition with the given geometry, then give
    // the FSM a cycle to settle before any pixel arrives.
    task automatic startFrame(input logic [15:0] w, input logic [15:0] h);
        dec_idle = 1'b1;
        step();
        img_width  = w;
        img_height = h;
        dec_idle   = 1'b0;
        step();
        step();
    endtask

    function automatic logic [31:0] expPix(input logic [7:0] r, input logic [7:0] g,
                                           input logic [7:0] b);
`ifdef JPEG_SINK_RGB565_EN
        return {16'h0, r[7:3], g[7:2], b[7:3]};
`else
        return {8'h0, r, g, b};
`endif
    endfunction

    initial begin
        rst_n      = 1'b0;
        dec_idle   = 1'b1;
        m_ready    = 1'b0;
        img_width  = 16'd0;
        img_height = 16'd0;
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h00);
        step();
        step();

        // Reset state.
        checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
        checkOutput("rst_m_data", 32'(m_data), 32'd0);
        checkOutput("rst_level", 32'(fifo_level), 32'd0);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        checkOutput("rst_stray", 32'(stray), 32'd0);
        checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
        rst_n = 1'b1;
        step();

        // 4x2 frame with m_ready held high: one beat per pixel.
        $display("[TB] 4x2 frame, streaming");
        m_ready = 1'b1;
        startFrame(16'd4, 16'd2);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 8'h10 + 8'(i), 8'h40 + 8'(i), 8'h80 + 8'(i));
            step();
            checkOutput($sformatf("f1_valid_%0d", i), 32'(m_valid), 32'd1);
            checkOutput($sformatf("f1_data_%0d", i), 32'(m_data),
                        expPix(8'h10 + 8'(i), 8'h40 + 8'(i), 8'h80 + 8'(i)));
            checkOutput($sformatf("f1_sof_%0d", i), 32'(m_sof), (i == 0) ? 32'd1 : 32'd0);
            checkOutput($sformatf("f1_eol_%0d", i), 32'(m_eol),
                        (i == 3 || i == 7) ? 32'd1 : 32'd0);
            checkOutput($sformatf("f1_eof_%0d", i), 32'(m_eof), (i == 7) ? 32'd1 : 32'd0);
            checkOutput($sformatf("f1_done_%0d", i), 32'(frame_done), 32'd0);
        end
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h00);
        step();
        checkOutput("f1_done_pulse", 32'(frame_done), 32'd1);
        checkOutput("f1_empty", 32'(m_valid), 32'd0);
        step();
        checkOutput("f1_done_clear", 32'(frame_done), 32'd0);
        checkOutput("f1_overflow", 32'(overflow), 32'd0);
        checkOutput("f1_stray", 32'(stray), 32'd0);

        // 32x1 frame with m_ready low: FIFO fills, the rest overflow incl. eof.
        $display("[TB] 32x1 frame, overflow");
        m_ready = 1'b0;
        startFrame(16'd32, 16'd1);
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b1, 8'(i), 8'hA0, 8'h05);
            step();
            if (i == 19) begin
                checkOutput("f2_level_full", 32'(fifo_level), 32'd16);
                checkOutput("f2_overflow", 32'(overflow), 32'd1);
            end
        end
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h00);
        step();
        checkOutput("f2_level_hold", 32'(fifo_level), 32'd16);
        checkOutput("f2_no_early_done", 32'(frame_done), 32'd0);
        m_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            checkOutput($sformatf("f2_valid_%0d", k), 32'(m_valid), 32'd1);
            checkOutput($sformatf("f2_data_%0d", k), 32'(m_data), expPix(8'(k), 8'hA0, 8'h05));
            checkOutput($sformatf("f2_sof_%0d", k), 32'(m_sof), (k == 0) ? 32'd1 : 32'd0);
            checkOutput($sformatf("f2_eof_%0d", k), 32'(m_eof), 32'd0);
            step();
        end
        checkOutput("f2_drained", 32'(m_valid), 32'd0);
        checkOutput("f2_level_zero", 32'(fifo_level), 32'd0);
        checkOutput("f2_done_wait", 32'(frame_done), 32'd0);
        step();
        checkOutput("f2_done_pulse", 32'(frame_done), 32'd1);
        step();
        checkOutput("f2_done_clear", 32'(frame_done), 32'd0);
        checkOutput("f2_overflow_sticky", 32'(overflow), 32'd1);

        // Pixels while the decoder is idle are stray.
        $display("[TB] stray pixels in IDLE");
        dec_idle = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 8'h11, 8'h22, 8'h33);
            step();
        end
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h00);
        step();
        checkOutput("idle_level", 32'(fifo_level), 32'd0);
        checkOutput("idle_valid", 32'(m_valid), 32'd0);
        checkOutput("idle_stray", 32'(stray), 32'd1);

        // Zero-width frame start clears flags but never activates.
        $display("[TB] zero-width frame");
        startFrame(16'd0, 16'd2);
        checkOutput("w0_stray_cleared", 32'(stray), 32'd0);
        checkOutput("w0_overflow_cleared", 32'(overflow), 32'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 8'h55, 8'h66, 8'h77);
            step();
            checkOutput($sformatf("w0_level_%0d", i), 32'(fifo_level), 32'd0);
            checkOutput($sformatf("w0_done_%0d", i), 32'(frame_done), 32'd0);
        end
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h00);
        step();
        checkOutput("w0_stray", 32'(stray), 32'd1);
        checkOutput("w0_done_final", 32'(frame_done), 32'd0);

        // Reset in the middle of a 4x2 frame flushes immediately.
        $display("[TB] mid-frame reset");
        m_ready = 1'b0;
        startFrame(16'd4, 16'd2);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 8'hC0 + 8'(i), 8'h01, 8'h02);
            step();
        end
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h00);
        checkOutput("mr_level_before", 32'(fifo_level), 32'd3);
        rst_n    = 1'b0;
        dec_idle = 1'b1;
        #1;
        checkOutput("mr_valid_now", 32'(m_valid), 32'd0);
        checkOutput("mr_level_now", 32'(fifo_level), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // New frame after reset: first pixel tagged sof, packing checked.
        m_ready = 1'b1;
        startFrame(16'd4, 16'd2);
        applyStimulus(1'b1, 8'hFF, 8'h80, 8'h08);
        step();
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h00);
        checkOutput("mr_first_valid", 32'(m_valid), 32'd1);
        checkOutput("mr_first_sof", 32'(m_sof), 32'd1);
`ifdef JPEG_SINK_RGB565_EN
        checkOutput("pack_rgb565", 32'(m_data), 32'h0000FC01);
`else
        checkOutput("pack_rgb888", 32'(m_data), 32'h00FF8008);
`endif
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/jpeg_pixel_sink.md
Name: jpeg_pixel_sink

Overview:
- Sits directly downstream of the JPEG decoder top and consumes its r/g/b + pixel_valid stream.
- The decoder output has no backpressure, so this block buffers pixels in a FIFO.
- It tags each pixel with start-of-frame / end-of-line / end-of-frame from the latched image size.
- It presents a valid/ready stream to the frame writer and flags overflow and stray pixels.

Parameters:
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW entries (default 16).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- r_in  input  8  decoder red
- g_in  input  8  decoder green
- b_in  input  8  decoder blue
- pixel_valid  input  1  decoder pixel strobe, one pixel per cycle, no stall possible
- dec_idle  input  1  decoder idle; a 1->0 transition marks frame start
- img_width  input  16  image width in pixels, sampled at frame start
- img_height  input  16  image height in pixels, sampled at frame start
- m_data  output  24 ({r,g,b}), 16 with RGB565_EN  pixel at FIFO head
- m_valid  output  1  FIFO non-empty
- m_ready  input  1  downstream accept
- m_sof  output  1  head pixel is (0,0)
- m_eol  output  1  head pixel is last of its line
- m_eof  output  1  head pixel is last of frame
- fifo_level  output  FIFO_AW+1  current occupancy
- overflow  output  1  sticky: pixel dropped because the FIFO was full
- stray  output  1  sticky: pixel_valid outside an active frame
- frame_done  output  1  one-cycle pulse when the last pixel of a frame has been accepted downstream

Behaviour:
- Reset: all outputs 0, FIFO empty, x/y=0, state IDLE, dec_idle edge register=1. rst_n asserted mid-frame flushes the FIFO and discards the frame.
- FSM states: IDLE, ACTIVE, DRAIN.
  - IDLE: on registered dec_idle falling edge, latch width/height, clear x, y, overflow, stray.
    - If width==0 or height==0: remain in IDLE.
    - Otherwise go to ACTIVE.
    - pixel_valid in IDLE: pixel dropped, stray<=1.
  - ACTIVE: each pixel_valid forms the entry {data, sof=(x==0&&y==0), eol=(x==W-1), eof=(x==W-1&&y==H-1)}.
    - x increments; at x==W-1, x wraps to 0 and y increments.
    - On writing the eof pixel, go to DRAIN. x/y then wrap to 0 and are not used further.
  - DRAIN: pixel_valid is dropped and sets stray. When the eof entry handshakes (m_valid&&m_ready&&m_eof), frame_done=1 for the next cycle and the FSM returns to IDLE.
  - Frame-start edge outside IDLE: ignored.
- FIFO write condition: pixel_valid && ACTIVE && (!full || (m_valid&&m_ready)). A write into a full FIFO in the same cycle as a read is accepted.
  - If the write is blocked: overflow<=1, pixel lost, but x/y still advance so tags stay aligned to image coordinates.
  - If the eof pixel itself is dropped, the FSM still goes to DRAIN and frame_done fires once the FIFO is empty.
- FIFO is first-word-fall-through: a pixel written in cycle N is visible on m_valid/m_data in cycle N+1.
- m_data/m_sof/m_eol/m_eof hold stable while m_valid && !m_ready.
- Simultaneous read+write: fifo_level unchanged.
- Sticky flags clear only at reset or the next frame start.

Optional Feature:
- Macro: JPEG_SINK_RGB565_EN.
- Defined: m_data is 16-bit {r[7:3], g[7:2], b[7:3]}, FIFO data width is 16.
- Undefined: m_data is 24-bit {r, g, b}.
- Tags and control behaviour are identical in both cases.

Test Plan:
- Frame 4x2, m_ready=1, 8 consecutive pixels -> 8 beats; m_sof on beat 0; m_eol on beats 3 and 7; m_eof on beat 7; frame_done pulse 1 cycle after beat 7 accepted; overflow=0, stray=0.
- FIFO_AW=4, frame 32x1, m_ready=0 during 20 pixels -> fifo_level=16, overflow=1. Then m_ready=1 -> 16 beats drained; the last pixel was dropped, so no beat has eof, and frame_done pulses once the FIFO is empty.
- pixel_valid pulses while dec_idle=1 (IDLE) -> fifo_level stays 0, stray=1. The next frame start clears stray.
- img_width=0 at frame start -> FSM stays IDLE, pixels dropped, stray=1, frame_done never asserts.
- JPEG_SINK_RGB565_EN defined, pixel r=0xFF g=0x80 b=0x08 -> m_data=16'hFC01. Undefined -> m_data=24'hFF8008.
- rst_n low after 3 of 8 pixels of a 4x2 frame -> m_valid=0 and fifo_level=0 immediately. A new frame start after release sees m_sof on its first pixel.
